// File: rtl/ldpc_onchip_mem_pipe.sv
// ldpc_onchip_mem_pipe
// Parametrised single-port on-chip RAM behind a pipelined Avalon-MM slave.
// Sits between the LDPC interconnect and the decoder message/LLR buffers.
// After reset the array can be swept to zero while waitrequest is held.
// Reads return 1+OUT_REG cycles after the accept edge, in order, one per cycle.

module ldpc_onchip_mem_pipe #(
   parameter int DATA_W         = 32,
   parameter int ADDR_W         = 13,
   parameter int DEPTH          = 8192,
   parameter int OUT_REG        = 0,
   parameter int CLEAR_ON_RESET = 1
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                reset_req,
   input  logic                clken,
   input  logic                chipselect,
   input  logic                read,
   input  logic                write,
   input  logic [ADDR_W-1:0]   address,
   input  logic [DATA_W/8-1:0] byteenable,
   input  logic [DATA_W-1:0]   writedata,
   output logic                waitrequest,
   output logic [DATA_W-1:0]   readdata,
   output logic                readdatavalid,
   output logic                clear_done
);

   localparam int NB    = DATA_W / 8;
   localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   // Output stages after the capture register: one always, one more with OUT_REG.
   localparam int NSTG  = 1 + OUT_REG;

   localparam logic [ADDR_W:0]   DEPTH_V  = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] CLR_LAST = ADDR_W'(DEPTH - 1);

   localparam logic [0:0] ST_CLEAR = 1'b0;
   localparam logic [0:0] ST_RUN   = 1'b1;

   // Without a sweep the block comes out of reset already running.
   localparam logic [0:0] ST_RESET = (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_RUN;
   localparam logic       CD_RESET = (CLEAR_ON_RESET != 0) ? 1'b0 : 1'b1;

   logic [DATA_W-1:0] mem [DEPTH];

   logic              en;
   logic [0:0]        state_q, state_d;
   logic [ADDR_W-1:0] clr_cnt_q, clr_cnt_d;
   logic              clear_done_q, clear_done_d;

   logic              inRange;
   logic              accept;
   logic              wrAccept;
   logic              rdAccept;
   logic [IDX_W-1:0]  idx;
   logic [IDX_W-1:0]  clrIdx;

   logic [DATA_W-1:0] raw_q;
   logic              cap_vld_q;
   logic              cap_oor_q;
   logic [DATA_W-1:0] capData;

   logic [NSTG-1:0]   vld_q;
   logic [DATA_W-1:0] dat_q [NSTG];

   // reset_req is treated as a clock-enable drop so the whole block freezes.
   assign en = clken & ~reset_req;

   // Requests are only taken while running and enabled.
   assign waitrequest = (state_q != ST_RUN) | ~en;

   // Addresses beyond DEPTH are dropped on write and read back as zero.
   assign inRange  = ({1'b0, address} < DEPTH_V);
   assign accept   = chipselect & (read | write) & ~waitrequest;
   assign wrAccept = accept & write & inRange;
   assign rdAccept = accept & read & ~write;

   assign idx    = address[IDX_W-1:0];
   assign clrIdx = clr_cnt_q[IDX_W-1:0];

   // Sweep sequencing: step through every word once, then enter RUN for good.
   always_comb begin
      state_d      = state_q;
      clr_cnt_d    = clr_cnt_q;
      clear_done_d = clear_done_q;
      if (en && (state_q == ST_CLEAR)) begin
         clr_cnt_d = clr_cnt_q + 1'b1;
         if (clr_cnt_q == CLR_LAST) begin
            state_d      = ST_RUN;
            clear_done_d = 1'b1;
         end
      end
   end

   // Control state; a reset in mid-sweep restarts the sweep from word zero.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q      <= ST_RESET;
         clr_cnt_q    <= '0;
         clear_done_q <= CD_RESET;
      end else begin
         state_q      <= state_d;
         clr_cnt_q    <= clr_cnt_d;
         clear_done_q <= clear_done_d;
      end
   end

   assign clear_done = clear_done_q;

   // Storage array plus the raw read capture, kept reset-free so it maps onto block RAM.
   always_ff @(posedge clk) begin
      if (en) begin
         if (state_q == ST_CLEAR) begin
            mem[clrIdx] <= '0;
         end else if (wrAccept) begin
            for (int b = 0; b < NB; b++) begin
               if (byteenable[b]) begin
                  mem[idx][8*b +: 8] <= writedata[8*b +: 8];
               end
            end
         end
         if (rdAccept && inRange) begin
            raw_q <= mem[idx];
         end
      end
   end

   // Capture-stage tags: whether a read was accepted and whether it was out of range.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cap_vld_q <= 1'b0;
         cap_oor_q <= 1'b0;
      end else if (en) begin
         cap_vld_q <= rdAccept;
         if (rdAccept) begin
            cap_oor_q <= ~inRange;
         end
      end
   end

   assign capData = cap_oor_q ? '0 : raw_q;

   // Output pipeline; data only advances with a valid, so readdata holds between pulses.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         vld_q <= '0;
         for (int s = 0; s < NSTG; s++) begin
            dat_q[s] <= '0;
         end
      end else if (en) begin
         vld_q[0] <= cap_vld_q;
         if (cap_vld_q) begin
            dat_q[0] <= capData;
         end
         for (int s = 1; s < NSTG; s++) begin
            vld_q[s] <= vld_q[s-1];
            if (vld_q[s-1]) begin
               dat_q[s] <= dat_q[s-1];
            end
         end
      end
   end

   assign readdata      = dat_q[NSTG-1];
   assign readdatavalid = vld_q[NSTG-1];

endmodule

// File: doc/ldpc_onchip_mem_pipe.md
Name: ldpc_onchip_mem_pipe

Overview:
- Parametrised single-port on-chip RAM behind a pipelined Avalon-MM slave. Successor to the fixed 8192x32 unregistered program/data memory in the LDPC subsystem.
- Adds generic width and depth, and a selectable output register with readdatavalid.
- Adds a hardware zero-clear sweep after reset, with waitrequest held during the sweep.
- Adds out-of-range address protection for non-power-of-two depths.
- Sits between the LDPC interconnect and the decoder message/LLR buffers.

Parameters:
- DATA_W, 32, data width in bits; must be a multiple of 8.
- ADDR_W, 13, address width in words.
- DEPTH, 8192, number of words; must satisfy 1 <= DEPTH <= 2**ADDR_W.
- OUT_REG, 0, read latency is 1 cycle when 0 and 2 cycles when 1 (extra output register).
- CLEAR_ON_RESET, 1, when 1 the array is swept to zero after reset.

Ports:
- clk  in  1  sole clock; all logic on its rising edge.
- reset  in  1  asynchronous, active-high reset.
- reset_req  in  1  when 1, behaves exactly as clken=0.
- clken  in  1  global clock enable; 0 freezes all state.
- chipselect  in  1  slave select.
- read  in  1  read request.
- write  in  1  write request.
- address  in  ADDR_W  word address.
- byteenable  in  DATA_W/8  write byte lanes.
- writedata  in  DATA_W  write data.
- waitrequest  out  1  1 = request not accepted this cycle.
- readdata  out  DATA_W  read data.
- readdatavalid  out  1  single-cycle pulse marking valid readdata.
- clear_done  out  1  1 once the post-reset sweep has completed.

Behaviour:
- Reset values while reset=1, applied asynchronously:
  - readdata=0, readdatavalid=0, read pipeline flushed.
  - state=CLEAR, clr_cnt=0.
  - clear_done=0, waitrequest=1 if CLEAR_ON_RESET=1.
  - clear_done=1, waitrequest=0, state=RUN if CLEAR_ON_RESET=0.
- Enable: en = clken & ~reset_req. With en=0:
  - No state, counter, array or pipeline register changes.
  - waitrequest=1.
  - readdata and readdatavalid hold their values. A valid pulse that was high stays high until en returns.
- CLEAR state:
  - Each en cycle writes 0 to all bytes of mem[clr_cnt], then clr_cnt++.
  - When clr_cnt=DEPTH-1 is written: next state RUN, clear_done=1. clear_done stays 1 until the next reset.
  - Sweep takes exactly DEPTH en-cycles.
  - waitrequest=1 throughout; bus requests are ignored, never queued.
  - Reset asserted mid-sweep restarts the sweep from address 0.
- RUN state: waitrequest = ~en. A request is accepted when chipselect & (read | write) & ~waitrequest.
- Accepted write:
  - Byte lane i of mem[address] is updated iff byteenable[i]=1.
  - byteenable=0 is a legal no-op.
  - Address >= DEPTH: write is discarded, no aliasing.
- Accepted read:
  - Array is sampled at the accept edge.
  - readdatavalid pulses for one cycle with readdata, 1+OUT_REG cycles after accept. Accept at edge N gives data and valid visible after edge N+1+OUT_REG.
  - Back-to-back reads sustain one read per cycle, returned in order.
  - Address >= DEPTH: returns readdata=0 with valid asserted normally.
  - readdata holds its last value when readdatavalid=0.
- Simultaneous read=1 and write=1 in one accepted cycle: write is performed, read is dropped (no valid pulse).
- Read following a write to the same address on the next cycle returns the new data. Read-during-write cannot occur: a single request is accepted per cycle.
- Array contents are not initialised by reset itself; only the sweep clears them. With CLEAR_ON_RESET=0, contents are undefined until written.
- No combinational path from any input to readdata or readdatavalid. waitrequest is combinational from state, clken and reset_req only.

Test Plan:
1. Reset then clear sweep, DEPTH=16, CLEAR_ON_RESET=1, en=1:
   - waitrequest=1 for exactly 16 cycles after reset release, then 0.
   - clear_done rises on cycle 16.
   - Reads of all 16 addresses return 0.
2. Pipelined reads, OUT_REG=0 then OUT_REG=1:
   - Write 0xA5A5_0001..0xA5A5_0004 to addresses 0..3, then 4 back-to-back reads.
   - valid pulses on 4 consecutive cycles, data in order, first valid at 1 (OUT_REG=0) or 2 (OUT_REG=1) cycles after the first accept.
3. Byte enables:
   - Write 0xFFFFFFFF to addr 5, then write 0x12345678 with byteenable=4'b0101.
   - Read of addr 5 returns 0xFF34FF78.
4. Freeze mid-stream:
   - Accept read of addr 2, then drop clken for 3 cycles.
   - waitrequest=1 and no new valid during the freeze.
   - The pending valid appears exactly one cycle after clken returns (OUT_REG=0), data correct.
   - Repeat the sequence using reset_req instead of clken; response is identical.
5. Out-of-range, DEPTH=12, ADDR_W=4:
   - Write 0xDEAD to addr 13: mem[1] unchanged.
   - Read addr 13 returns 0 with valid.
6. Reset mid-sweep:
   - Assert reset at clr_cnt=7 (DEPTH=16).
   - Sweep restarts at 0 and waitrequest stays 1 for 16 full cycles.
   - Simultaneous read+write to addr 3 with data 0x55: write performed, no valid pulse.
